// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, unpacker FSM states and coefficient-width check
package kyber_pkg;
  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic d_legal(input logic [3:0] d);
    return d != 4'd0 && d <= 4'd12;
  endfunction
endpackage

// File: rtl/bit_repacker.sv
// bit_repacker: LSB-first bit buffer that absorbs IW-bit words and yields NLANE d-bit lanes
module bit_repacker #(
  parameter int IW = 64,
  parameter int NLANE = 4,
  parameter int CW = 12
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic [3:0]         i_d,
  input  logic [IW-1:0]      i_din,
  input  logic               i_push,
  input  logic               i_pop,
  output logic               o_avail,
  output logic               o_room,
  output logic [NLANE*CW-1:0] o_lanes
);
  localparam int BW = IW + NLANE * CW;
  localparam int FW = $clog2(BW + 1);
  logic [BW-1:0] bits_q, bits_n;
  logic [FW-1:0] fill_q, fill_n, beat_bits, pop_bits, kept;
  logic [CW-1:0] mask;
  assign beat_bits = FW'(NLANE) * FW'(i_d);
  assign pop_bits = i_pop ? beat_bits : '0;
  assign kept = fill_q - pop_bits;
  assign o_avail = fill_q >= beat_bits;
  // room is judged after this cycle's pop so a full-rate stream never bubbles
  assign o_room = {1'b0, kept} + (FW+1)'(IW) <= (FW+1)'(BW);
  assign mask = CW'((1 << i_d) - 1);
  assign bits_n = (bits_q >> pop_bits) | (i_push ? BW'(i_din) << kept : '0);
  assign fill_n = kept + (i_push ? FW'(IW) : '0);
  always_comb begin
    o_lanes = '0;
    for (int k = 0; k < NLANE; k++)
      o_lanes[k*CW +: CW] = CW'(bits_q >> (k * int'(i_d))) & mask;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      bits_q <= '0;
      fill_q <= '0;
    end else if (i_clr) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_n;
      fill_q <= fill_n;
    end
endmodule

// File: rtl/poly_unpack.sv
// poly_unpack: decodes one 256-coefficient d-bit packed polynomial into NLANE-wide beats.
// Optional POLY_UNPACK_MODQ_CHK_EN reduces d=12 coefficients >= q and flags them on o_err.
module poly_unpack import kyber_pkg::*; #(
  parameter int IW = 64,
  parameter int NLANE = 4,
  parameter int CW = 12
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [3:0]          i_d,
  input  logic [IW-1:0]       i_ibytes,
  input  logic                i_ibytes_valid,
  output logic                o_ibytes_ready,
  output logic [NLANE*CW-1:0] o_coeffs,
  output logic                o_coeffs_valid,
  input  logic                i_coeffs_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);
  state_t state_q, state_n;
  logic [3:0] d_q;
  logic [9:0] words_q;
  logic [8:0] beats_q;
  logic err_q, avail, room, push, pop, start_ok;
  logic [NLANE*CW-1:0] lanes;
  assign start_ok = state_q == IDLE && i_start;
  assign o_ibytes_ready = state_q == RUN && words_q != '0 && room;
  assign o_coeffs_valid = state_q == RUN && avail;
  assign push = i_ibytes_valid && o_ibytes_ready;
  assign pop = o_coeffs_valid && i_coeffs_ready;
  assign o_busy = state_q == RUN;
  assign o_done = state_q == DONE;
  assign o_err = err_q;
  bit_repacker #(.IW(IW), .NLANE(NLANE), .CW(CW)) u_rep (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(start_ok && d_legal(i_d)), .i_d(d_q),
    .i_din(i_ibytes), .i_push(push), .i_pop(pop),
    .o_avail(avail), .o_room(room), .o_lanes(lanes)
  );
`ifdef POLY_UNPACK_MODQ_CHK_EN
  logic hit;
  always_comb begin
    o_coeffs = lanes;
    hit = 1'b0;
    for (int k = 0; k < NLANE; k++)
      if (d_q == 4'd12 && lanes[k*CW +: CW] >= CW'(KYBER_Q)) begin
        o_coeffs[k*CW +: CW] = lanes[k*CW +: CW] - CW'(KYBER_Q);
        hit = 1'b1;
      end
  end
`else
  assign o_coeffs = lanes;
`endif
  always_comb begin
    state_n = state_q;
    if (start_ok && d_legal(i_d)) state_n = RUN;
    if (state_q == RUN && pop && beats_q == 9'd1) state_n = DONE;
    if (state_q == DONE) state_n = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state_q <= IDLE;
    else state_q <= state_n;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      d_q <= '0;
      words_q <= '0;
      beats_q <= '0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= !d_legal(i_d);
      if (d_legal(i_d)) begin
        d_q <= i_d;
        words_q <= 10'(i_d) * 10'(KYBER_N / IW);
        beats_q <= 9'(KYBER_N / NLANE);
      end
    end else begin
      words_q <= words_q - {9'd0, push};
      beats_q <= beats_q - {8'd0, pop};
`ifdef POLY_UNPACK_MODQ_CHK_EN
      if (pop && hit) err_q <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_poly_unpack.sv
// tb_poly_unpack: table-driven polynomial runs against a bitstream model plus reset/error sequences
module tb_poly_unpack;
  localparam int IW = 64, NLANE = 4, CW = 12, OW = NLANE * CW;
  logic i_clk = 0, i_rstn = 0, i_start = 0, i_ibytes_valid = 0, i_coeffs_ready = 0;
  logic [3:0] i_d = '0;
  logic [IW-1:0] i_ibytes = '0;
  logic o_ibytes_ready, o_coeffs_valid, o_busy, o_done, o_err;
  logic [OW-1:0] o_coeffs;
  int total = 0, bad = 0;
  logic [63:0] words [0:191];
  logic [OW-1:0] first_beat;
  int wi, bi;
  typedef struct { int d; int pat; int bp_at; int bp_len; } vec_t;
  vec_t tbl [0:5];

  always #5 i_clk = ~i_clk;

  poly_unpack #(.IW(IW), .NLANE(NLANE), .CW(CW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_d(i_d),
    .i_ibytes(i_ibytes), .i_ibytes_valid(i_ibytes_valid), .o_ibytes_ready(o_ibytes_ready),
    .o_coeffs(o_coeffs), .o_coeffs_valid(o_coeffs_valid), .i_coeffs_ready(i_coeffs_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // pat 0: all ones, 1: 0x01234567 then random, 2: single 0xD01 coefficient, 3: random
  task automatic build(input int d, input int pat);
    for (int j = 0; j < 4 * d; j++)
      words[j] = pat == 0 ? 64'hFFFF_FFFF_FFFF_FFFF :
                 pat == 2 ? (j == 0 ? 64'h0000_0000_0000_0D01 : 64'h0) :
                 (pat == 1 && j == 0) ? 64'h0000_0000_0123_4567 : {$urandom, $urandom};
  endtask

  function automatic logic [CW-1:0] coef(input int d, input int n);
    logic [CW-1:0] c = '0;
    for (int b = 0; b < d; b++) c[b] = words[(n * d + b) / 64][(n * d + b) % 64];
`ifdef POLY_UNPACK_MODQ_CHK_EN
    if (d == 12 && c >= 12'd3329) c = c - 12'd3329;
`endif
    return c;
  endfunction

  function automatic logic raw_over_q(input int d);
    logic any = 1'b0;
    for (int n = 0; n < 256; n++) begin
      logic [CW-1:0] c = '0;
      for (int b = 0; b < d; b++) c[b] = words[(n * d + b) / 64][(n * d + b) % 64];
      if (d == 12 && c >= 12'd3329) any = 1'b1;
    end
    return any;
  endfunction

  function automatic logic exp_err(input int d);
`ifdef POLY_UNPACK_MODQ_CHK_EN
    return raw_over_q(d);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OW-1:0] beat(input int d, input int n);
    logic [OW-1:0] b = '0;
    for (int k = 0; k < NLANE; k++) b[k*CW +: CW] = coef(d, n * NLANE + k);
    return b;
  endfunction

  task automatic start(input logic [3:0] d);
    @(negedge i_clk);
    i_start = 1; i_d = d;
    @(negedge i_clk);
    i_start = 0;
  endtask

  task automatic run(input int d, input int pat, input int bp_at, input int bp_len);
    int nw = 4 * d, cyc = 0;
    logic stall = 0, done_due = 0, seen_drop = 0;
    logic [OW-1:0] held = '0;
    build(d, pat);
    start(4'(d));
    wi = 0; bi = 0;
    check("busy_after_start", o_busy, 1);
    check("err_clear_on_start", o_err, 0);
    while (cyc < 3000) begin
      i_ibytes_valid = 1;
      i_ibytes = wi < nw ? words[wi] : 64'hDEAD_BEEF_0BAD_F00D;
      i_coeffs_ready = !(cyc >= bp_at && cyc < bp_at + bp_len);
      i_start = cyc == 3;
      i_d = cyc == 3 ? 4'(d % 12 + 1) : 4'(d);
      #1;
      if (done_due) begin
        check("done_pulse", o_done, 1);
        check("busy_low_at_done", o_busy, 0);
        break;
      end
      if (stall) begin
        check("stall_valid", o_coeffs_valid, 1);
        check("stall_hold", o_coeffs, held);
      end
      if (!i_coeffs_ready && !o_ibytes_ready && wi < nw) seen_drop = 1;
      if (o_ibytes_ready) wi++;
      if (o_coeffs_valid && i_coeffs_ready) begin
        if (bi == 0) first_beat = o_coeffs;
        check($sformatf("d%0d_beat%0d", d, bi), o_coeffs, beat(d, bi));
        bi++;
        if (bi == 256 / NLANE) done_due = 1;
      end
      stall = o_coeffs_valid && !i_coeffs_ready;
      held = o_coeffs;
      cyc++;
      @(negedge i_clk);
    end
    i_start = 0;
    check("run_completed", done_due, 1);
    @(negedge i_clk);
    #1;
    check("done_single", o_done, 0);
    check("words_accepted", wi, nw);
    check("ready_low_after", o_ibytes_ready, 0);
    check("err_end", o_err, exp_err(d));
    if (bp_len > 0) check("ibytes_ready_dropped", seen_drop, 1);
    i_ibytes_valid = 0;
  endtask

  initial begin
    tbl[0] = '{1, 0, -1, 0};
    tbl[1] = '{12, 1, -1, 0};
    tbl[2] = '{12, 2, -1, 0};
    tbl[3] = '{5, 3, 20, 10};
    tbl[4] = '{8, 3, 15, 10};
    tbl[5] = '{4, 3, -1, 0};
    #1;
    check("reset_flags", {o_ibytes_ready, o_coeffs_valid, o_busy, o_done, o_err}, 0);
    check("reset_coeffs", o_coeffs, 0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1;
    // illegal width: error flag, stays idle, no words taken
    start(4'd13);
    check("bad_d_err", o_err, 1);
    check("bad_d_busy", o_busy, 0);
    i_ibytes_valid = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bad_d_no_accept", o_ibytes_ready, 0);
      @(negedge i_clk);
    end
    i_ibytes_valid = 0;
    // reset after seven words of a d=5 run
    build(5, 3);
    start(4'd5);
    wi = 0;
    i_coeffs_ready = 1;
    i_ibytes_valid = 1;
    for (int c = 0; c < 200 && wi < 7; c++) begin
      i_ibytes = words[wi];
      #1;
      if (o_ibytes_ready) wi++;
      @(negedge i_clk);
    end
    check("reset_at_word7", wi, 7);
    i_rstn = 0;
    #1;
    check("midrun_reset_flags", {o_ibytes_ready, o_coeffs_valid, o_busy, o_done, o_err}, 0);
    @(negedge i_clk);
    #1;
    check("midrun_reset_coeffs", o_coeffs, 0);
    check("midrun_reset_busy", o_busy, 0);
    i_ibytes_valid = 0;
    i_rstn = 1;
    run(5, 3, -1, 0);
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].d, tbl[i].pat, tbl[i].bp_at, tbl[i].bp_len);
      if (i == 0) check("d1_beat0", first_beat, 48'h001_001_001_001);
      if (i == 1) check("d12_beat0", first_beat, 48'h000_001_234_567);
      if (i == 2) begin
`ifdef POLY_UNPACK_MODQ_CHK_EN
        check("modq_lane0", first_beat[11:0], 12'h000);
`else
        check("modq_lane0", first_beat[11:0], 12'hD01);
`endif
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/poly_unpack.md
POLY_UNPACK -- requirements
Module: poly_unpack

Interface
REQ-001 SHALL have parameter IW, 64, input word width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter NLANE, 4, coefficients per output beat; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter CW, 12, output lane width in bits.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1, one-cycle request to begin decoding one 256-coefficient polynomial.
REQ-007 SHALL have port i_d, input, 4, coefficient bit width d, sampled when i_start is taken.
REQ-008 SHALL have port i_ibytes, input, IW, packed input word.
REQ-009 SHALL have port i_ibytes_valid, input, 1, input word valid.
REQ-010 SHALL have port o_ibytes_ready, output, 1, input word accepted when valid and ready are both high.
REQ-011 SHALL have port o_coeffs, output, NLANE*CW, coefficient beat; lane k at [k*CW +: CW].
REQ-012 SHALL have port o_coeffs_valid, output, 1, output beat valid.
REQ-013 SHALL have port i_coeffs_ready, input, 1, downstream backpressure.
REQ-014 SHALL have port o_busy, output, 1, high from start acceptance until o_done.
REQ-015 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port o_err, output, 1, error flag (see REQ-027, REQ-030).

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on i_start with legal i_d; RUN->DONE after the beat holding coefficient 255 is accepted; DONE->IDLE after one cycle.
REQ-018 SHALL treat input as a continuous LSB-first bitstream: word j supplies stream bits [j*IW +: IW]; coefficient n = stream bits [n*d +: d], zero-extended to CW.
REQ-019 SHALL accept exactly 256*d/IW words per polynomial; o_ibytes_ready low in IDLE, DONE, and after the last word.
REQ-020 SHALL hold a bit buffer of IW+NLANE*CW bits with a fill counter; o_ibytes_ready high in RUN only if fill+IW fits.
REQ-021 SHALL assert o_coeffs_valid when fill >= NLANE*d; beat n carries coefficients n*NLANE .. n*NLANE+NLANE-1; 256/NLANE beats per polynomial.
REQ-022 SHALL keep o_coeffs and o_coeffs_valid stable while valid and not i_coeffs_ready.
REQ-023 SHALL allow input acceptance and output beat consumption in the same cycle; fill updates by +IW and -NLANE*d together.
REQ-024 SHALL present the first beat registered, no earlier than the cycle after the first word that completes NLANE*d bits.
REQ-025 SHALL sustain one beat per cycle whenever NLANE*d <= IW and both sides are ready.
REQ-026 SHALL pulse o_done in the cycle after the final beat is accepted; o_busy falls with the o_done pulse.
REQ-027 SHALL ignore i_start with i_d of 0 or 13-15, stay in IDLE, and set o_err.
REQ-028 SHALL ignore i_start while o_busy is high; o_err clears on the next legal start.

Reset
REQ-029 SHALL clear, on i_rstn low at any time including mid-polynomial, state to IDLE, fill to 0, and counters to 0, with o_ibytes_ready=0, o_coeffs=0, o_coeffs_valid=0, o_busy=0, o_done=0, o_err=0; buffered bits are discarded.

Configuration
REQ-030 SHALL support macro POLY_UNPACK_MODQ_CHK_EN: when defined and d=12, each coefficient >= 3329 is output minus 3329 and sets o_err, sticky until the next legal start; when undefined, coefficients pass unmodified and o_err reflects only REQ-027.

Structure
REQ-031 SHALL take KYBER_N=256, KYBER_Q=3329, the legal-d check function, and the state enum from shared package kyber_pkg.
REQ-032 SHALL place the bit buffer with fill/extract logic in sub-module bit_repacker; the FSM, counters and mod-q check stay in poly_unpack.

Verification
REQ-033 SHALL cover d=1, IW=64, NLANE=4: four words 0xFFFF_FFFF_FFFF_FFFF -> 64 beats of 0x001_001_001_001, then one o_done pulse.
REQ-034 SHALL cover d=12: word0 0x0000_0000_0123_4567 -> beat0 lanes 0x567, 0x234, 0x001, 0x000; exactly 48 words accepted.
REQ-035 SHALL cover backpressure: i_coeffs_ready low for 10 cycles mid-run -> o_coeffs stable, o_ibytes_ready drops when the buffer is full, and no coefficient is lost or duplicated vs the golden model.
REQ-036 SHALL cover mod-q: d=12 coefficient 0xD01 -> with the macro, lane 0x000 and o_err=1; without it, lane 0xD01 and o_err=0.
REQ-037 SHALL cover reset at word 7 of a d=5 run -> all outputs 0 next cycle; a subsequent full d=5 run (20 words) matches the golden model.
REQ-038 SHALL cover i_start with i_d=13 -> o_err=1, o_busy stays 0, and no words accepted.
